pipe_latch_buf: RTL and testbench

//   Parametrised elastic pipeline latch between processor stages (e.g. IF/ID, ID/EX).

---
 rtl/pipe_latch_buf.sv | 84 ++++++++
 tb/tb_pipe_latch_buf.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_latch_buf.sv
// pipe_latch_buf: DEPTH-entry elastic latch between pipeline stages with valid/ready,
// synchronous flush and occupancy count. Define PIPE_LATCH_BYPASS_EN for empty-buffer pass-through.
module pipe_latch_buf #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_STEP   = AW'(1);
  localparam logic [CW-1:0] CNT_STEP   = CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_passThrough;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_COUNT);
  assign in_ready = !w_full;
  assign count    = r_count;

`ifdef PIPE_LATCH_BYPASS_EN
  logic w_bypass;

  // An empty, unflushed buffer exposes the upstream word directly; if it is taken
  // in the same cycle it never touches storage.
  assign w_bypass      = w_empty && !flush;
  assign w_passThrough = w_bypass && in_valid && out_ready;
  assign out_valid     = w_bypass ? in_valid : !w_empty;
  assign out_data      = w_bypass ? in_data : (w_empty ? '0 : r_mem[r_rdPtr]);
`else
  assign w_passThrough = 1'b0;
  assign out_valid     = !w_empty;
  assign out_data      = w_empty ? '0 : r_mem[r_rdPtr];
`endif

  assign w_push = in_valid && !w_full && !w_passThrough;
  assign w_pop  = !w_empty && out_ready;

  // Flush outranks both push and pop, so a squashed word is never recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_STEP;
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_STEP;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_STEP;
        2'b01:   r_count <= r_count - CNT_STEP;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wrPtr] <= in_data;
  end

endmodule

// File: tb/tb_pipe_latch_buf.sv
// tb_pipe_latch_buf: drives a DEPTH=2 and a DEPTH=4 instance and compares every cycle
// against a queue-based model of an elastic FIFO latch.
module tb_pipe_latch_buf;

`ifdef PIPE_LATCH_BYPASS_EN
  localparam bit BYPASS_ON = 1'b1;
`else
  localparam bit BYPASS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        flushA, inValidA, inReadyA, outValidA, outReadyA;
  logic [15:0] inDataA, outDataA;
  logic [1:0]  countA;
  logic        flushB, inValidB, inReadyB, outValidB, outReadyB;
  logic [15:0] inDataB, outDataB;
  logic [2:0]  countB;

  pipe_latch_buf #(.WIDTH(16), .DEPTH(2)) dutA (
    .clk(clk), .rst_n(rst_n), .flush(flushA),
    .in_valid(inValidA), .in_data(inDataA), .in_ready(inReadyA),
    .out_valid(outValidA), .out_data(outDataA), .out_ready(outReadyA),
    .count(countA)
  );

  pipe_latch_buf #(.WIDTH(16), .DEPTH(4)) dutB (
    .clk(clk), .rst_n(rst_n), .flush(flushB),
    .in_valid(inValidB), .in_data(inDataB), .in_ready(inReadyB),
    .out_valid(outValidB), .out_data(outDataB), .out_ready(outReadyB),
    .count(countB)
  );

  int errors = 0;
  int checks = 0;
  int activeDepth = 2;
  logic [15:0] modelQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic driveInputs(input bit v, input logic [15:0] d, input bit r, input bit f);
    if (activeDepth == 2) begin
      inValidA = v; inDataA = d; outReadyA = r; flushA = f;
      inValidB = 1'b0; inDataB = '0; outReadyB = 1'b0; flushB = 1'b0;
    end else begin
      inValidB = v; inDataB = d; outReadyB = r; flushB = f;
      inValidA = 1'b0; inDataA = '0; outReadyA = 1'b0; flushA = 1'b0;
    end
  endtask

  // One clock cycle: drive, compare outputs mid-cycle with the model, clock, update the model.
  task automatic applyStimulus(input string tag, input bit v, input logic [15:0] d,
                               input bit r, input bit f);
    int sz;
    bit byp;
    logic        expValid, obsValid, obsReady;
    logic [15:0] expData, obsData;
    int          obsCount;
    driveInputs(v, d, r, f);
    @(negedge clk);
    sz       = modelQ.size();
    byp      = BYPASS_ON && (sz == 0) && !f;
    expValid = byp ? v : (sz != 0);
    expData  = byp ? d : ((sz != 0) ? modelQ[0] : 16'h0);
    obsValid = (activeDepth == 2) ? outValidA : outValidB;
    obsData  = (activeDepth == 2) ? outDataA  : outDataB;
    obsReady = (activeDepth == 2) ? inReadyA  : inReadyB;
    obsCount = (activeDepth == 2) ? int'(countA) : int'(countB);
    checkOutput({tag, ".out_valid"}, 32'(obsValid), 32'(expValid));
    checkOutput({tag, ".out_data"},  32'(obsData),  32'(expData));
    checkOutput({tag, ".in_ready"},  32'(obsReady), 32'(sz != activeDepth));
    checkOutput({tag, ".count"},     32'(obsCount), 32'(sz));
    if (f) begin
      modelQ.delete();
    end else if (!(byp && v && r)) begin
      bit doPush;
      doPush = v && (sz != activeDepth);
      if (sz != 0 && r) void'(modelQ.pop_front());
      if (doPush) modelQ.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    driveInputs(1'b0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelQ.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    activeDepth = 2;
    driveInputs(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    checkOutput("rst.countA", 32'(countA), 32'd0);
    checkOutput("rst.countB", 32'(countB), 32'd0);
    checkOutput("rst.validA", 32'(outValidA), 32'd0);
    checkOutput("rst.dataB", 32'(outDataB), 32'd0);
    checkOutput("rst.readyB", 32'(inReadyB), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-cycle while holding one word.
    applyStimulus("arst.load", 1'b1, 16'h4242, 1'b0, 1'b0);
    driveInputs(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    checkOutput("arst.pre_count", 32'(countA), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst.count", 32'(countA), 32'd0);
    checkOutput("arst.out_valid", 32'(outValidA), 32'd0);
    checkOutput("arst.out_data", 32'(outDataA), 32'd0);
    checkOutput("arst.in_ready", 32'(inReadyA), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    modelQ.delete();
    @(posedge clk);
    #1;

    applyStimulus("stream", 1'b1, 16'h1111, 1'b1, 1'b0);
    applyStimulus("stream", 1'b1, 16'h2222, 1'b1, 1'b0);
    applyStimulus("stream", 1'b1, 16'h3333, 1'b1, 1'b0);
    applyStimulus("stream", 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus("stream", 1'b0, 16'h0000, 1'b1, 1'b0);

    resetDut();
    applyStimulus("bp", 1'b1, 16'hAAAA, 1'b0, 1'b0);
    applyStimulus("bp", 1'b1, 16'hBBBB, 1'b0, 1'b0);
    applyStimulus("bp.full", 1'b1, 16'hCCCC, 1'b0, 1'b0);
    applyStimulus("bp.full", 1'b1, 16'hCCCC, 1'b0, 1'b0);
    applyStimulus("bp.drain", 1'b1, 16'hCCCC, 1'b1, 1'b0);
    applyStimulus("bp.drain", 1'b1, 16'hCCCC, 1'b1, 1'b0);
    applyStimulus("bp.drain", 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus("bp.drain", 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus("bp.empty", 1'b0, 16'h0000, 1'b1, 1'b0);

    resetDut();
    applyStimulus("flush.fill", 1'b1, 16'h1234, 1'b0, 1'b0);
    applyStimulus("flush.fill", 1'b1, 16'h5678, 1'b0, 1'b0);
    applyStimulus("flush", 1'b1, 16'h5555, 1'b1, 1'b1);
    applyStimulus("flush.after", 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus("flush.after", 1'b0, 16'h0000, 1'b1, 1'b0);

    resetDut();
    applyStimulus("bypass", 1'b1, 16'h7E7E, 1'b1, 1'b0);
    applyStimulus("bypass.next", 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus("bypass.idle", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Wrap on DEPTH=4: fill to each level, then run push/pop pairs, then drain.
    activeDepth = 4;
    resetDut();
    for (int lvl = 1; lvl <= 4; lvl++) begin
      for (int k = 0; k < lvl; k++)
        applyStimulus("wrap.fill", 1'b1, 16'($urandom), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++)
        applyStimulus("wrap.pair", 1'b1, 16'($urandom), 1'b1, 1'b0);
      for (int k = 0; k < 5; k++)
        applyStimulus("wrap.drain", 1'b0, 16'h0000, 1'b1, 1'b0);
    end

    for (int n = 0; n < 400; n++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 3) != 0),
                    16'($urandom),
                    ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 23) == 0));
    end

    activeDepth = 2;
    resetDut();
    for (int n = 0; n < 200; n++) begin
      applyStimulus("randA",
                    ($urandom_range(0, 1) != 0),
                    16'($urandom),
                    ($urandom_range(0, 1) != 0),
                    ($urandom_range(0, 31) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
